// File: rtl/axis_frame_arbiter.sv
// Two-input AXIS frame arbiter: grants one source per frame and holds it until that
// frame's tlast handshake, muxing the granted source onto the master port with zero latency.
module axis_frame_arbiter #(
  parameter int unsigned width     = 8,
  parameter bit          rr_mode   = 1'b1,
  parameter int unsigned cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [width-1:0]     s0_axis_tdata,
  input  logic                 s0_axis_tvalid,
  input  logic                 s0_axis_tlast,
  output logic                 s0_axis_tready,
  input  logic [width-1:0]     s1_axis_tdata,
  input  logic                 s1_axis_tvalid,
  input  logic                 s1_axis_tlast,
  output logic                 s1_axis_tready,
  output logic [width-1:0]     m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 sel,
  output logic                 busy,
  output logic [cnt_width-1:0] s0_frame_cnt,
  output logic [cnt_width-1:0] s1_frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   req_c;
  logic   pick1_c;
  logic   done0_c;
  logic   done1_c;

  // s1 wins when it is the only requester, or under round-robin when s0 had the last grant
  assign req_c   = s0_axis_tvalid | s1_axis_tvalid;
  assign pick1_c = s1_axis_tvalid & (~s0_axis_tvalid | (rr_mode & ~last_grant));
  assign done0_c = (state == GNT0) & s0_axis_tvalid & m_axis_tready & s0_axis_tlast;
  assign done1_c = (state == GNT1) & s1_axis_tvalid & m_axis_tready & s1_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= 1'b0;
      last_grant   <= 1'b1;
      s0_frame_cnt <= '0;
      s1_frame_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_c) begin
            state      <= pick1_c ? GNT1 : GNT0;
            sel        <= pick1_c;
            last_grant <= pick1_c;
          end
        end
        GNT0: begin
          if (done0_c) begin
            state        <= IDLE;
            s0_frame_cnt <= s0_frame_cnt + cnt_width'(1);
          end
        end
        GNT1: begin
          if (done1_c) begin
            state        <= IDLE;
            s1_frame_cnt <= s1_frame_cnt + cnt_width'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Granted source is passed straight through; everything is quiet while idle
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    busy           = 1'b0;
    unique case (state)
      GNT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
        busy           = 1'b1;
      end
      GNT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
        busy           = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Randomized bench for axis_frame_arbiter: a round-robin/16-bit-counter instance and a
// fixed-priority/2-bit-counter instance, each checked every cycle against a frame-ownership model.
module tb_axis_frame_arbiter;

  localparam int unsigned W      = 8;
  localparam int unsigned NCYC   = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam bit          RR = (g == 0);
    localparam int unsigned CW = (g == 0) ? 16 : 2;

    logic          rst;
    logic [W-1:0]  d0, d1, md;
    logic          v0, v1, l0, l1, r0, r1;
    logic          mv, ml, mr, sel, busy;
    logic [CW-1:0] c0, c1;

    axis_frame_arbiter #(.width(W), .rr_mode(RR), .cnt_width(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .s0_axis_tdata  (d0),
      .s0_axis_tvalid (v0),
      .s0_axis_tlast  (l0),
      .s0_axis_tready (r0),
      .s1_axis_tdata  (d1),
      .s1_axis_tvalid (v1),
      .s1_axis_tlast  (l1),
      .s1_axis_tready (r1),
      .m_axis_tdata   (md),
      .m_axis_tvalid  (mv),
      .m_axis_tlast   (ml),
      .m_axis_tready  (mr),
      .sel            (sel),
      .busy           (busy),
      .s0_frame_cnt   (c0),
      .s1_frame_cnt   (c1)
    );

    // Model: owner is the source holding the current frame (-1 = nobody)
    initial begin
      int    owner;
      int    pick;
      int    cnt0, cnt1;
      int    modn;
      bit    lg, esel, known, pop0, pop1;
      string pfx;

      modn  = 1 << CW;
      owner = -1;
      cnt0  = 0;
      cnt1  = 0;
      lg    = 1'b1;
      esel  = 1'b0;
      known = 1'b0;
      rst   = 1'b1;
      v0    = 1'b1;
      v1    = 1'b1;
      d0    = W'($urandom);
      d1    = W'($urandom);
      l0    = 1'b0;
      l1    = 1'b1;
      mr    = 1'b1;

      for (int cyc = 0; cyc < int'(NCYC); cyc++) begin
        @(negedge clk);
        pfx = $sformatf("i%0d c%0d", g, cyc);
        if (known) begin
          if (owner < 0) begin
            check({pfx, " m_tvalid"}, 32'(mv), 32'd0);
            check({pfx, " m_tlast"},  32'(ml), 32'd0);
            check({pfx, " m_tdata"},  32'(md), 32'd0);
            check({pfx, " s0_tready"}, 32'(r0), 32'd0);
            check({pfx, " s1_tready"}, 32'(r1), 32'd0);
            check({pfx, " busy"},     32'(busy), 32'd0);
          end else begin
            check({pfx, " m_tvalid"}, 32'(mv), 32'(owner == 1 ? v1 : v0));
            check({pfx, " m_tlast"},  32'(ml), 32'(owner == 1 ? l1 : l0));
            check({pfx, " m_tdata"},  32'(md), 32'(owner == 1 ? d1 : d0));
            check({pfx, " s0_tready"}, 32'(r0), 32'(owner == 0 ? mr : 1'b0));
            check({pfx, " s1_tready"}, 32'(r1), 32'(owner == 1 ? mr : 1'b0));
            check({pfx, " busy"},     32'(busy), 32'd1);
          end
          check({pfx, " sel"},  32'(sel), 32'(esel));
          check({pfx, " cnt0"}, 32'(c0), 32'(cnt0));
          check({pfx, " cnt1"}, 32'(c1), 32'(cnt1));
        end

        // Next model state from the inputs sampled at the coming edge
        if (rst) begin
          owner = -1;
          esel  = 1'b0;
          lg    = 1'b1;
          cnt0  = 0;
          cnt1  = 0;
          known = 1'b1;
        end else if (known) begin
          if (owner < 0) begin
            pick = -1;
            if (v0 && v1)  pick = RR ? (lg ? 0 : 1) : 0;
            else if (v0)   pick = 0;
            else if (v1)   pick = 1;
            if (pick >= 0) begin
              owner = pick;
              esel  = (pick == 1);
              lg    = (pick == 1);
            end
          end else if (owner == 0 && v0 && mr && l0) begin
            owner = -1;
            cnt0  = (cnt0 + 1) % modn;
          end else if (owner == 1 && v1 && mr && l1) begin
            owner = -1;
            cnt1  = (cnt1 + 1) % modn;
          end
        end

        // Sources follow AXIS: a presented beat holds until the DUT accepts it
        pop0 = v0 && r0;
        pop1 = v1 && r1;
        @(posedge clk);
        #1;
        if (pop0 || !v0) begin
          v0 = ($urandom % 10) < 7;
          d0 = W'($urandom);
          l0 = ($urandom % 3) == 0;
        end
        if (pop1 || !v1) begin
          v1 = ($urandom % 10) < 7;
          d1 = W'($urandom);
          l1 = ($urandom % 3) == 0;
        end
        mr  = ($urandom % 4) != 0;
        rst = (cyc < 1) || (($urandom % 150) == 0);
      end
      n_done++;
    end
  end

  initial begin
    wait (n_done == 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(NCYC * 10 * 4);
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench did not complete");
  end

endmodule
